wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Writeback stage that drives the register file write port (wr_en/wr_addr/wr_data).
- Merges single-cycle ALU results with multi-cycle FP16 unit results. FPU results are buffered in a small FIFO.
- Keeps a per-register pending scoreboard that decode uses for stall decisions.
- Outputs are registered on posedge clk. The register file captures them on the following negedge.

Parameters:
DATA_W, 16, register/result width
ADDR_W, 4, register address width
FIFO_DEPTH, 4, FPU result FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock, posedge
reset  input  1  synchronous, active-high
alu_valid  input  1  ALU result present this cycle
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
alu_stall  output  1  ALU result not accepted this cycle; producer holds valid/addr/data
fpu_valid  input  1  FPU result present
fpu_ready  output  1  FIFO can accept an FPU result
fpu_addr  input  ADDR_W  FPU destination register
fpu_data  input  DATA_W  FPU result
issue_valid  input  1  multi-cycle FPU op issued this cycle
issue_addr  input  ADDR_W  destination of issued op
pending  output  15  bit i = r[i] awaiting FPU writeback
fifo_count  output  3  current FIFO occupancy (0..FIFO_DEPTH)
wr_en  output  1  register file write enable
wr_addr  output  ADDR_W  register file write address
wr_data  output  DATA_W  register file write data

Behaviour:
- Reset (synchronous, active-high):
  - wr_en=0, wr_addr=0, wr_data=0.
  - FIFO emptied, fifo_count=0, pending=0.
  - fpu_ready=0 and alu_stall=0 while reset is high.
- Reset mid-operation discards all FIFO contents and clears all pending bits. No write issues in the cycle after reset.
- FPU accept:
  - fpu_ready = !reset && (fifo_count < FIFO_DEPTH), combinational from the registered count.
  - A transfer occurs when fpu_valid && fpu_ready. The entry is pushed at the posedge.
  - An FPU result never bypasses the FIFO.
- Selection each cycle, at most one write:
  - Case 1, fifo_count == FIFO_DEPTH: the FIFO head wins. alu_stall = alu_valid. The ALU is not accepted.
  - Case 2, else if alu_valid: the ALU wins. alu_stall=0. The FIFO head waits.
  - Case 3, else if fifo_count > 0: the FIFO head is popped.
  - Case 4, otherwise: idle.
- Output registers:
  - The selected source loads wr_addr/wr_data at the posedge. wr_en=1 for exactly one cycle per accepted result.
  - wr_addr/wr_data hold their last value when wr_en=0.
- Latency (cycle numbers are posedges):
  - ALU sampled at posedge k produces wr_en high after posedge k.
  - FPU pushed at posedge k into an empty FIFO with no ALU activity produces wr_en high after posedge k+1.
- Address 15 (PC alias, read-only):
  - A result addressed to 15 is accepted (consumed, popped if from the FIFO) but produces wr_en=0.
  - issue_addr=15 is ignored.
- Simultaneous push and pop in one cycle: fifo_count is unchanged. Ordering is strictly FIFO. Pointers wrap modulo FIFO_DEPTH.
- Pending scoreboard:
  - issue_valid sets pending[issue_addr] at the posedge.
  - When an FPU entry with address a is selected for write, pending[a] clears at the same posedge.
  - If set and clear target the same address in one cycle, the set wins.
  - ALU writes never modify pending.
  - WAW ordering between ALU and FPU to the same register is decode's responsibility. The block makes no attempt to reorder.
- fifo_count never exceeds FIFO_DEPTH. A pop with count 0 never occurs.

Test Plan:
1. ALU only: reset, then alu_valid=1, alu_addr=3, alu_data=16'h3C00 for one cycle -> one cycle later wr_en=1, wr_addr=3, wr_data=16'h3C00; next cycle wr_en=0.
2. FPU path with scoreboard: issue_valid, issue_addr=5 -> pending=15'h0020. Then fpu_valid, addr=5, data=16'h4200 -> wr_en two posedges later, wr_addr=5, wr_data=16'h4200. pending returns to 0 at the posedge that loads the write.
3. Priority and backpressure:
   - Push 4 FPU results (r1..r4, data 1..4) while alu_valid is held high to r7 -> ALU writes r7 each cycle until count=4.
   - Then fpu_ready=0 and alu_stall=1; head r1 drains, count drops to 3, and the ALU wins the next cycle.
   - All of r1..r4 are eventually written, in order.
4. Address 15: ALU write to 15 with data 16'hBEEF, and FPU entry to 15 -> wr_en stays 0; the FIFO entry is popped (count decrements); pending is unchanged.
5. Reset mid-op: FIFO holds 3 entries and pending=15'h000E; assert reset for one cycle -> fifo_count=0, pending=0, wr_en=0; no stale writes afterward.
6. Same-cycle set/clear: FPU result to r2 popped while issue_valid targets r2 -> pending[2]=1 after the edge; a write of r2 still occurs.

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Writeback arbiter driving the register file write port. Merges
//            single-cycle ALU results with buffered multi-cycle FP16 results
//            and maintains a per-register pending scoreboard for decode.
// Ports    : clk, reset         - clock (posedge) and sync active-high reset
//            alu_valid/addr/data - ALU result; alu_stall = not accepted
//            fpu_valid/addr/data - FPU result; fpu_ready = FIFO has room
//            issue_valid/addr    - multi-cycle FPU op issued (sets pending)
//            pending             - bit i set while r[i] awaits FPU writeback
//            fifo_count          - FPU result FIFO occupancy
//            wr_en/addr/data     - registered register file write port
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             alu_valid,
  input  logic [ADDR_W-1:0]                alu_addr,
  input  logic [DATA_W-1:0]                alu_data,
  output logic                             alu_stall,
  input  logic                             fpu_valid,
  output logic                             fpu_ready,
  input  logic [ADDR_W-1:0]                fpu_addr,
  input  logic [DATA_W-1:0]                fpu_data,
  input  logic                             issue_valid,
  input  logic [ADDR_W-1:0]                issue_addr,
  output logic [(2**ADDR_W)-2:0]           pending,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             wr_en,
  output logic [ADDR_W-1:0]                wr_addr,
  output logic [DATA_W-1:0]                wr_data
);

  localparam int                  c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int                  c_CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int                  c_NREG    = (2**ADDR_W) - 1;
  // Highest address aliases the PC and is never written.
  localparam logic [ADDR_W-1:0]   c_PC_ADDR = '1;
  localparam logic [c_CNT_W-1:0]  c_FULL    = c_CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0]  r_mem_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]  r_mem_data [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_NREG-1:0]  r_pending;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_take_alu;
  logic               w_write;
  logic [ADDR_W-1:0]  w_head_addr;
  logic [DATA_W-1:0]  w_head_data;
  logic [ADDR_W-1:0]  w_src_addr;
  logic [DATA_W-1:0]  w_src_data;
  logic [c_NREG-1:0]  w_pending_nxt;

  assign w_full      = (r_count == c_FULL);
  assign w_empty     = (r_count == '0);
  assign w_head_addr = r_mem_addr[r_rd_ptr];
  assign w_head_data = r_mem_data[r_rd_ptr];

  assign fpu_ready   = !reset && !w_full;
  // A full FIFO takes priority so it can always drain and unblock the FPU.
  assign alu_stall   = !reset && w_full && alu_valid;

  assign w_push      = fpu_valid && fpu_ready;
  assign w_pop       = !reset && (w_full || (!alu_valid && !w_empty));
  assign w_take_alu  = !reset && !w_full && alu_valid;

  assign w_src_addr  = w_pop ? w_head_addr : alu_addr;
  assign w_src_data  = w_pop ? w_head_data : alu_data;
  // PC-addressed results are consumed but never reach the register file.
  assign w_write     = (w_pop || w_take_alu) && (w_src_addr != c_PC_ADDR);

  // Clear on FIFO pop, then set on issue so a same-cycle set wins.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int i = 0; i < c_NREG; i++) begin
      w_pending_nxt[i] = (issue_valid && (issue_addr == ADDR_W'(i))) ||
                         (r_pending[i] && !(w_pop && (w_head_addr == ADDR_W'(i))));
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= fpu_addr;
      r_mem_data[r_wr_ptr] <= fpu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_pending <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_pending <= w_pending_nxt;
      r_wr_en   <= w_write;
      if (w_write) begin
        r_wr_addr <= w_src_addr;
        r_wr_data <= w_src_data;
      end
    end
  end

  assign pending    = r_pending;
  assign fifo_count = r_count;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;

endmodule
`default_nettype wire
